// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory address, captures
// the returned word into a one-entry ready/valid buffer, and handles redirect, halt and fault.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd400,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] DR,
    input  logic [31:0] INS,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        halted,
    output logic        err,
    output logic [15:0] fcount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ir_n, ir_pc_n;
    logic        ir_valid_n;
    logic        xfer, slot_free, aligned;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign DR        = pc;
    assign xfer      = ir_valid && ir_ready;
    assign slot_free = !ir_valid || ir_ready;
    assign aligned   = (redirect_pc[1:0] == 2'b00);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ir_pc_n    = ir_pc;
        // A handshake empties the buffer unless a fire refills it below.
        ir_valid_n = ir_valid && !xfer;

        case (state)
            IDLE, RUN, HALT: begin
                if (redirect) begin
                    ir_valid_n = 1'b0;
                    if (!aligned) begin
                        state_n = FAULT;
                    end else begin
                        pc_n = redirect_pc;
                        if (state == HALT || (state == IDLE && en)) begin
                            state_n = RUN;
                        end
                    end
                end else if (state == IDLE) begin
                    if (en) begin
                        state_n = RUN;
                    end
                end else if (state == RUN) begin
                    if (!en) begin
                        state_n = IDLE;
                    end else if (slot_free) begin
                        if (pc >= MEM_BYTES) begin
                            state_n = FAULT;
                        end else if (INS == HALT_WORD) begin
                            state_n = HALT;
                        end else begin
                            ir_n       = INS;
                            ir_pc_n    = pc;
                            ir_valid_n = 1'b1;
                            pc_n       = pc + 32'd4;
                        end
                    end
                end
            end
            default: begin
                // FAULT is sticky; only reset leaves it.
                state_n = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= 32'd0;
            ir_pc    <= 32'd0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
            fcount   <= 16'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
            halted   <= (state_n == HALT);
            err      <= (state_n == FAULT);
            if (xfer) begin
                fcount <= sat_inc16(fcount);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with hand-derived expectations plus
// randomized traffic checked against a buffer-level reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam int          MEMB   = 400;

    logic        clk = 1'b0;
    logic        rst, en, redirect, ir_ready;
    logic [31:0] redirect_pc;
    logic [31:0] DR, INS, ir, ir_pc;
    logic        ir_valid, halted, err;
    logic [15:0] fcount;

    logic [31:0] mem [0:127];
    int tests = 0;
    int fails = 0;

    // Reference model: a program counter, a one-entry buffer and an operating mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
    int          m_mode;
    logic [31:0] m_pc, m_ir, m_ir_pc;
    bit          m_full;
    int          m_fcount;

    always #5 clk = ~clk;

    assign INS = (DR < 32'd512) ? mem[DR[8:2]] : 32'hDEAD_BEEF;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(32'd400),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .DR         (DR),
        .INS        (INS),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .halted     (halted),
        .err        (err),
        .fcount     (fcount)
    );

    task automatic model_step();
        logic [31:0] word;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0;
            m_full = 1'b0; m_fcount = 0;
            return;
        end
        if (m_full && ir_ready) begin
            m_full   = 1'b0;
            m_fcount = (m_fcount >= 65535) ? 65535 : m_fcount + 1;
        end
        if (m_mode == M_FAULT) return;
        if (redirect) begin
            m_full = 1'b0;
            if (redirect_pc % 4 != 0) begin
                m_mode = M_FAULT;
            end else begin
                m_pc = redirect_pc;
                if (m_mode == M_HALT || (m_mode == M_IDLE && en)) m_mode = M_RUN;
            end
        end else if (m_mode == M_IDLE) begin
            if (en) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!en) begin
                m_mode = M_IDLE;
            end else if (!m_full) begin
                if (m_pc >= MEMB) begin
                    m_mode = M_FAULT;
                end else begin
                    word = mem[m_pc / 4];
                    if (word == HALT_W) begin
                        m_mode = M_HALT;
                    end else begin
                        m_ir = word; m_ir_pc = m_pc; m_full = 1'b1; m_pc = m_pc + 4;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    endtask

    task automatic test_reset();
        en = 1'b1; ir_ready = 1'b1;
        tick(); tick(); tick();
        do_reset();
        tests++; if (DR !== 32'd0) begin fails++; $display("FAIL reset_dr got=%h exp=%h", DR, 32'd0); end
        tests++; if (ir !== 32'd0) begin fails++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'd0); end
        tests++; if (ir_pc !== 32'd0) begin fails++; $display("FAIL reset_ir_pc got=%h exp=%h", ir_pc, 32'd0); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        tests++; if (halted !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", halted, err); end
        tests++; if (fcount !== 16'd0) begin fails++; $display("FAIL reset_fcount got=%0d exp=0", fcount); end
        // Idle without enable: no fetch.
        tick(); tick();
        tests++; if (ir_valid !== 1'b0 || DR !== 32'd0) begin fails++; $display("FAIL idle_nofetch got=%b/%h exp=0/0", ir_valid, DR); end
    endtask

    task automatic test_stream();
        do_reset();
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
        en = 1'b1; ir_ready = 1'b1;
        tick();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL stream_lat got=%b exp=0", ir_valid); end
        tick();
        tests++; if (ir !== 32'hAAAA_0001 || ir_pc !== 32'd0 || ir_valid !== 1'b1) begin fails++; $display("FAIL stream_a got=%h@%h v%b exp=aaaa0001@0 v1", ir, ir_pc, ir_valid); end
        tests++; if (DR !== 32'd4) begin fails++; $display("FAIL stream_dr got=%h exp=4", DR); end
        tick();
        tests++; if (ir !== 32'hBBBB_0002 || ir_pc !== 32'd4) begin fails++; $display("FAIL stream_b got=%h@%h exp=bbbb0002@4", ir, ir_pc); end
        tick();
        tests++; if (ir !== 32'hCCCC_0003 || ir_pc !== 32'd8) begin fails++; $display("FAIL stream_c got=%h@%h exp=cccc0003@8", ir, ir_pc); end
        tick();
        tests++; if (fcount !== 16'd3) begin fails++; $display("FAIL stream_fcount got=%0d exp=3", fcount); end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        tick(); tick(); tick();
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (ir !== mem[1] || ir_pc !== 32'd4 || DR !== 32'd8 || ir_valid !== 1'b1) begin fails++; $display("FAIL bp_hold%0d got=%h@%h dr=%h exp=%h@4 dr=8", k, ir, ir_pc, DR, mem[1]); end
        end
        ir_ready = 1'b1;
        tick();
        tests++; if (ir !== mem[2] || ir_pc !== 32'd8) begin fails++; $display("FAIL bp_release got=%h@%h exp=%h@8", ir, ir_pc, mem[2]); end
        tests++; if (fcount !== 16'd2) begin fails++; $display("FAIL bp_fcount got=%0d exp=2", fcount); end
        tick();
        tests++; if (ir_pc !== 32'd12) begin fails++; $display("FAIL bp_next got=%h exp=c", ir_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        tick(); tick(); tick(); tick();
        tests++; if (DR !== 32'd12 || ir_pc !== 32'd8) begin fails++; $display("FAIL redir_pre got=%h/%h exp=c/8", DR, ir_pc); end
        redirect = 1'b1; redirect_pc = 32'd100;
        tick();
        redirect = 1'b0;
        tests++; if (ir_valid !== 1'b0 || DR !== 32'd100) begin fails++; $display("FAIL redir_flush got=v%b dr=%h exp=v0 dr=64", ir_valid, DR); end
        tick();
        tests++; if (ir_pc !== 32'd100 || ir !== mem[25] || ir_valid !== 1'b1) begin fails++; $display("FAIL redir_target got=%h@%h exp=%h@64", ir, ir_pc, mem[25]); end
    endtask

    task automatic test_halt();
        mem[4] = HALT_W;
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        tests++; if (ir_pc !== 32'd12 || DR !== 32'd16) begin fails++; $display("FAIL halt_pre got=%h dr=%h exp=c dr=10", ir_pc, DR); end
        tick();
        tests++; if (halted !== 1'b1 || DR !== 32'd16 || ir_valid !== 1'b0) begin fails++; $display("FAIL halt_enter got=h%b dr=%h v%b exp=h1 dr=10 v0", halted, DR, ir_valid); end
        tick();
        tests++; if (halted !== 1'b1 || err !== 1'b0 || fcount !== 16'd4) begin fails++; $display("FAIL halt_stay got=h%b e%b f%0d exp=h1 e0 f4", halted, err, fcount); end
        en = 1'b0; redirect = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect = 1'b0; en = 1'b1;
        tests++; if (halted !== 1'b0 || DR !== 32'd0) begin fails++; $display("FAIL halt_exit got=h%b dr=%h exp=h0 dr=0", halted, DR); end
        tick();
        tests++; if (ir_pc !== 32'd0 || ir_valid !== 1'b1) begin fails++; $display("FAIL halt_resume got=%h v%b exp=0 v1", ir_pc, ir_valid); end
        mem[4] = 32'h1000_0010;
    endtask

    task automatic test_fault();
        bit seen;
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'd6;
        tick();
        redirect = 1'b0;
        tests++; if (err !== 1'b1 || ir_valid !== 1'b0 || DR !== 32'd8) begin fails++; $display("FAIL misalign got=e%b v%b dr=%h exp=e1 v0 dr=8", err, ir_valid, DR); end
        redirect = 1'b1; redirect_pc = 32'd0;
        tick(); redirect = 1'b0; tick(); tick();
        tests++; if (err !== 1'b1 || ir_valid !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL fault_sticky got=e%b v%b h%b exp=e1 v0 h0", err, ir_valid, halted); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (err !== 1'b0 || DR !== 32'd0) begin fails++; $display("FAIL fault_rst1 got=e%b dr=%h exp=e0 dr=0", err, DR); end
        // Straight-line fetch runs off the end of memory.
        en = 1'b1; ir_ready = 1'b1; seen = 1'b0;
        for (int k = 0; k < 150 && !seen; k++) begin
            tick();
            if (err) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL range_timeout got=err0 exp=err1 within 150 cycles"); end
        tests++; if (DR !== 32'd400 || ir_valid !== 1'b0 || fcount !== 16'd100) begin fails++; $display("FAIL range_fault got=dr%h v%b f%0d exp=dr190 v0 f100", DR, ir_valid, fcount); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (err !== 1'b0 || DR !== 32'd0) begin fails++; $display("FAIL fault_rst2 got=e%b dr=%h exp=e0 dr=0", err, DR); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        mem[30] = HALT_W; mem[70] = HALT_W;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 79) == 0);
            en          = ($urandom_range(0, 7) != 0);
            ir_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 32'($urandom_range(0, 127)) * 32'd4;
            if ($urandom_range(0, 15) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
            tick();
            tests++;
            if (DR !== m_pc || ir_valid !== m_full || fcount !== 16'(m_fcount) ||
                halted !== (m_mode == M_HALT) || err !== (m_mode == M_FAULT) ||
                (m_full && (ir !== m_ir || ir_pc !== m_ir_pc))) begin
                fails++; bad++;
                if (bad < 10)
                    $display("FAIL rand_c%0d got=dr%h v%b ir%h@%h f%0d h%b e%b exp=dr%h v%b ir%h@%h f%0d mode%0d",
                             c, DR, ir_valid, ir, ir_pc, fcount, halted, err,
                             m_pc, m_full, m_ir, m_ir_pc, m_fcount, m_mode);
            end
        end
        mem[30] = 32'h1000_0078; mem[70] = 32'h1000_0118;
    endtask

    task automatic test_saturation();
        int extra;
        extra = 0;
        do_reset();
        en = 1'b1; ir_ready = 1'b1;
        for (int c = 0; c < 80000 && extra < 100; c++) begin
            redirect = (c % 64 == 63); redirect_pc = 32'd0;
            tick();
            if (m_fcount == 65535) extra++;
        end
        redirect = 1'b0;
        tests++; if (extra < 100) begin fails++; $display("FAIL sat_timeout got=%0d exp=65535", m_fcount); end
        tests++; if (fcount !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got=%h exp=ffff", fcount); end
        tick(); tick();
        tests++; if (fcount !== 16'hFFFF || ir_valid !== 1'b1) begin fails++; $display("FAIL sat_more got=%h v%b exp=ffff v1", fcount, ir_valid); end
    endtask

    initial begin
        init_mem();
        rst = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        m_mode = M_IDLE; m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0; m_full = 1'b0; m_fcount = 0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
